// File: rtl/uart_baud_cfg_ctrl_if.sv
// Bus between the register file / UART datapath and the baud configuration controller.
//   cfg_wr_en, cfg_baud_val, cfg_frac : software baud write strobe and requested value
//   tx_busy, rx_busy                  : frame-in-progress indications from TX and RX
//   baud_tick                         : x16 baud enable from the generator
//   BAUD_VAL, BAUD_VAL_FRACTION       : active divisor and fraction to the generator
//   gen_restart                       : one-cycle reload of the generator counters
//   uart_quiesce                      : TX/RX must not start new frames while high
//   cfg_pending, cfg_done, cfg_forced : status back to the register file
interface uart_baud_cfg_ctrl_if;
  logic        cfg_wr_en;
  logic [12:0] cfg_baud_val;
  logic [2:0]  cfg_frac;
  logic        tx_busy;
  logic        rx_busy;
  logic        baud_tick;
  logic [12:0] BAUD_VAL;
  logic [2:0]  BAUD_VAL_FRACTION;
  logic        gen_restart;
  logic        uart_quiesce;
  logic        cfg_pending;
  logic        cfg_done;
  logic        cfg_forced;

  // Register file / datapath side
  modport master (
    output cfg_wr_en, cfg_baud_val, cfg_frac, tx_busy, rx_busy, baud_tick,
    input  BAUD_VAL, BAUD_VAL_FRACTION, gen_restart, uart_quiesce, cfg_pending, cfg_done,
           cfg_forced
  );

  // Controller side
  modport slave (
    input  cfg_wr_en, cfg_baud_val, cfg_frac, tx_busy, rx_busy, baud_tick,
    output BAUD_VAL, BAUD_VAL_FRACTION, gen_restart, uart_quiesce, cfg_pending, cfg_done,
           cfg_forced
  );
endinterface

// File: rtl/uart_baud_cfg_ctrl.sv
// Baud configuration sequencer. Shadows software baud writes, quiesces TX/RX, commits the
// new divisor/fraction at a safe point, restarts the generator and reports completion.
// Ports:
//   CLK   : single clock
//   RESET : synchronous active-high reset
//   bus   : uart_baud_cfg_ctrl_if.slave (write strobe, busy lines, tick in; baud value,
//           restart, quiesce and status out)
module uart_baud_cfg_ctrl #(
  parameter int unsigned BAUD_VAL_FRCTN_EN = 0,
  parameter logic [12:0] RESET_BAUD_VAL    = 13'd1,
  parameter logic [15:0] TIMEOUT_TICKS     = 16'd1024
) (
  input logic                 CLK,
  input logic                 RESET,
  uart_baud_cfg_ctrl_if.slave bus
);

  localparam logic [15:0] TimeoutLast = TIMEOUT_TICKS - 16'd1;

  typedef enum logic [1:0] {StIdle, StQuiesce, StApply, StSettle} state_e;

  state_e      st_q, st_d;
  logic [12:0] sh_val_q, sh_val_d;
  logic [2:0]  sh_frac_q, sh_frac_d;
  logic [12:0] baud_q, baud_d;
  logic [2:0]  frac_q, frac_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic        forced_q, forced_d;

  logic [2:0]  wr_frac;
  logic [12:0] nxt_val;
  logic [2:0]  nxt_frac;
  logic        differs;
  logic        idle_ok;
  logic        timeout;

  // Fraction is zeroed at the input so it never reaches the compare or the commit.
  assign wr_frac  = (BAUD_VAL_FRCTN_EN != 0) ? bus.cfg_frac : 3'b000;
  // Latest requested setting, including a write landing in this very cycle.
  assign nxt_val  = bus.cfg_wr_en ? bus.cfg_baud_val : sh_val_q;
  assign nxt_frac = bus.cfg_wr_en ? wr_frac : sh_frac_q;
  assign differs  = {nxt_val, nxt_frac} != {baud_q, frac_q};
  assign idle_ok  = !bus.tx_busy && !bus.rx_busy;
  assign timeout  = bus.baud_tick && (cnt_q == TimeoutLast);

  always_comb begin
    st_d      = st_q;
    sh_val_d  = nxt_val;
    sh_frac_d = nxt_frac;
    baud_d    = baud_q;
    frac_d    = frac_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    forced_d  = bus.cfg_wr_en ? 1'b0 : forced_q;

    case (st_q)
      StIdle: begin
        if (bus.cfg_wr_en) begin
          if (differs) begin
            st_d   = StQuiesce;
            pend_d = 1'b1;
            cnt_d  = 16'd0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StQuiesce: begin
        if (bus.baud_tick && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
        // Idle takes priority over timeout, so a forced commit is only flagged when busy.
        if (idle_ok || timeout) begin
          st_d     = StApply;
          baud_d   = nxt_val;
          frac_d   = nxt_frac;
          pend_d   = 1'b0;
          forced_d = !idle_ok;
        end
      end
      StApply: begin
        st_d = StSettle;
        if (bus.cfg_wr_en) begin
          pend_d = 1'b1;
        end
      end
      StSettle: begin
        if (bus.cfg_wr_en) begin
          pend_d = 1'b1;
        end
        if (bus.baud_tick) begin
          done_d = 1'b1;
          if ((pend_q || bus.cfg_wr_en) && differs) begin
            st_d   = StQuiesce;
            pend_d = 1'b1;
            cnt_d  = 16'd0;
          end else begin
            st_d   = StIdle;
            pend_d = 1'b0;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q      <= StIdle;
      sh_val_q  <= RESET_BAUD_VAL;
      sh_frac_q <= 3'b000;
      baud_q    <= RESET_BAUD_VAL;
      frac_q    <= 3'b000;
      cnt_q     <= 16'd0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      forced_q  <= 1'b0;
    end else begin
      st_q      <= st_d;
      sh_val_q  <= sh_val_d;
      sh_frac_q <= sh_frac_d;
      baud_q    <= baud_d;
      frac_q    <= frac_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      forced_q  <= forced_d;
    end
  end

  assign bus.BAUD_VAL          = baud_q;
  assign bus.BAUD_VAL_FRACTION = frac_q;
  assign bus.gen_restart       = (st_q == StApply);
  // Held through APPLY as well so no frame can start between quiesce and settle.
  assign bus.uart_quiesce      = (st_q != StIdle);
  assign bus.cfg_pending       = pend_q;
  assign bus.cfg_done          = done_q;
  assign bus.cfg_forced        = forced_q;

endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
module tb_uart_baud_cfg_ctrl;

  localparam int unsigned FracEn = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_baud_cfg_ctrl_if bus ();

  uart_baud_cfg_ctrl #(
    .BAUD_VAL_FRCTN_EN(FracEn),
    .RESET_BAUD_VAL   (13'd1),
    .TIMEOUT_TICKS    (16'd4)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the value software last saw committed.
  logic [12:0] act_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] rand_new();
    logic [12:0] v;
    do v = 13'($urandom_range(2, 8191)); while (v == act_val || v == 13'd50);
    return v;
  endfunction

  task automatic write(input logic [12:0] v, input logic [2:0] f);
    bus.cfg_wr_en    = 1'b1;
    bus.cfg_baud_val = v;
    bus.cfg_frac     = f;
    step();
    bus.cfg_wr_en    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_val"},     32'(bus.BAUD_VAL), 32'd1);
    chk({tag, "_frac"},    32'(bus.BAUD_VAL_FRACTION), 0);
    chk({tag, "_restart"}, 32'(bus.gen_restart), 0);
    chk({tag, "_quiesce"}, 32'(bus.uart_quiesce), 0);
    chk({tag, "_pending"}, 32'(bus.cfg_pending), 0);
    chk({tag, "_done"},    32'(bus.cfg_done), 0);
    chk({tag, "_forced"},  32'(bus.cfg_forced), 0);
  endtask

  // Write with an unchanged value: done next cycle, never quiesces.
  task automatic same_write(input string tag);
    write(act_val, 3'($urandom));
    chk({tag, "_done"},    32'(bus.cfg_done), 1);
    chk({tag, "_quiesce"}, 32'(bus.uart_quiesce), 0);
    chk({tag, "_val"},     32'(bus.BAUD_VAL), 32'(act_val));
    chk({tag, "_forced"},  32'(bus.cfg_forced), 0);
    step();
    chk({tag, "_done_clr"}, 32'(bus.cfg_done), 0);
  endtask

  // From APPLY: first tick in SETTLE gives done, then back to idle.
  task automatic settle(input logic tick_apply, input int w);
    logic ok;
    bus.baud_tick = tick_apply;
    step();
    bus.baud_tick = 1'b0;
    ok = (bus.gen_restart === 1'b0) && (bus.cfg_done === 1'b0) && (bus.uart_quiesce === 1'b1);
    for (int i = 0; i < w; i++) begin
      step();
      if (bus.cfg_done !== 1'b0 || bus.uart_quiesce !== 1'b1) ok = 1'b0;
    end
    chk("settle_wait", 32'(ok), 1);
    bus.baud_tick = 1'b1;
    step();
    bus.baud_tick = 1'b0;
    chk("settle_done",    32'(bus.cfg_done), 1);
    chk("settle_quiesce", 32'(bus.uart_quiesce), 0);
    chk("settle_pending", 32'(bus.cfg_pending), 0);
    chk("settle_val",     32'(bus.BAUD_VAL), 32'(act_val));
    step();
    chk("settle_done_clr", 32'(bus.cfg_done), 0);
  endtask

  task automatic commit(input logic [12:0] v, input logic [2:0] f, input int hold,
                        input logic tick_apply, input int w);
    logic ok;
    logic use_rx;
    use_rx = 1'($urandom_range(0, 1));
    write(v, f);
    chk("commit_quiesce", 32'(bus.uart_quiesce), 1);
    chk("commit_pending", 32'(bus.cfg_pending), 1);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (use_rx) bus.rx_busy = 1'b1;
      else        bus.tx_busy = 1'b1;
      step();
      if (bus.BAUD_VAL !== act_val || bus.uart_quiesce !== 1'b1 || bus.gen_restart !== 1'b0)
        ok = 1'b0;
    end
    if (hold > 0) chk("commit_busy_hold", 32'(ok), 1);
    bus.tx_busy = 1'b0;
    bus.rx_busy = 1'b0;
    step();
    chk("apply_restart", 32'(bus.gen_restart), 1);
    chk("apply_val",     32'(bus.BAUD_VAL), 32'(v));
    chk("apply_frac",    32'(bus.BAUD_VAL_FRACTION), (FracEn != 0) ? 32'(f) : 0);
    chk("apply_pending", 32'(bus.cfg_pending), 0);
    chk("apply_forced",  32'(bus.cfg_forced), 0);
    act_val = v;
    settle(tick_apply, w);
  endtask

  // rx stuck busy: commit forced on the 4th tick; a write in QUIESCE only updates the shadow.
  task automatic commit_timeout(input logic abort);
    logic ok;
    logic mid_done;
    int ticks;
    logic [12:0] v;
    v = rand_new();
    bus.rx_busy = 1'b1;
    write(v, 3'($urandom));
    ticks = 0;
    ok = 1'b1;
    mid_done = 1'b0;
    for (int c = 0; c < 400 && ticks < 4; c++) begin
      bus.baud_tick = ($urandom_range(0, 2) == 0) || (c % 5 == 4);
      if (ticks == 2 && !mid_done) begin
        v = rand_new();
        bus.cfg_wr_en = 1'b1;
        bus.cfg_baud_val = v;
        mid_done = 1'b1;
      end
      step();
      bus.cfg_wr_en = 1'b0;
      if (bus.baud_tick) ticks++;
      bus.baud_tick = 1'b0;
      if (ticks < 4 && (bus.gen_restart !== 1'b0 || bus.uart_quiesce !== 1'b1)) ok = 1'b0;
    end
    chk("timeout_hold",    32'(ok), 1);
    chk("timeout_ticks",   32'(ticks), 4);
    chk("timeout_restart", 32'(bus.gen_restart), 1);
    chk("timeout_val",     32'(bus.BAUD_VAL), 32'(v));
    chk("timeout_forced",  32'(bus.cfg_forced), 1);
    chk("timeout_pending", 32'(bus.cfg_pending), 0);
    act_val = v;
    if (abort) begin
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.rx_busy = 1'b0;
      act_val = 13'd1;
      check_reset_state("abort");
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
        bus.baud_tick = 1'($urandom_range(0, 1));
        step();
        if (bus.uart_quiesce !== 1'b0 || bus.BAUD_VAL !== 13'd1 || bus.cfg_pending !== 1'b0)
          ok = 1'b0;
      end
      bus.baud_tick = 1'b0;
      chk("abort_discard", 32'(ok), 1);
      same_write("abort_same");
    end else begin
      bus.rx_busy = 1'b0;
      settle(1'b0, $urandom_range(0, 3));
      chk("forced_sticky", 32'(bus.cfg_forced), 1);
      same_write("forced_clear");
    end
  endtask

  task automatic back_to_back(input logic in_apply, input logic same);
    logic [12:0] v1;
    logic [12:0] v2;
    v1 = rand_new();
    write(v1, 3'($urandom));
    step();
    chk("b2b_apply1", 32'(bus.BAUD_VAL), 32'(v1));
    act_val = v1;
    v2 = same ? v1 : rand_new();
    if (!in_apply) step();
    write(v2, 3'($urandom));
    chk("b2b_pending", 32'(bus.cfg_pending), 1);
    chk("b2b_quiesce", 32'(bus.uart_quiesce), 1);
    chk("b2b_nodone",  32'(bus.cfg_done), 0);
    bus.baud_tick = 1'b1;
    step();
    bus.baud_tick = 1'b0;
    chk("b2b_done1",   32'(bus.cfg_done), 1);
    chk("b2b_requies", 32'(bus.uart_quiesce), 32'(!same));
    chk("b2b_repend",  32'(bus.cfg_pending), 32'(!same));
    chk("b2b_val1",    32'(bus.BAUD_VAL), 32'(v1));
    if (!same) begin
      step();
      chk("b2b_restart2", 32'(bus.gen_restart), 1);
      chk("b2b_apply2",   32'(bus.BAUD_VAL), 32'(v2));
      act_val = v2;
      settle(1'b0, $urandom_range(0, 3));
    end else begin
      step();
      chk("b2b_done_clr", 32'(bus.cfg_done), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cfg_wr_en = 1'b0;
    bus.cfg_baud_val = 13'd0;
    bus.cfg_frac = 3'd0;
    bus.tx_busy = 1'b0;
    bus.rx_busy = 1'b0;
    bus.baud_tick = 1'b0;
    act_val = 13'd1;
    repeat (3) step();
    check_reset_state("reset");
    rst = 1'b0;
    step();
    same_write("same_reset_val");

    for (int r = 0; r < 3; r++) begin
      commit(rand_new(), 3'($urandom), $urandom_range(0, 6), 1'(r % 2), $urandom_range(0, 4));
    end
    commit(rand_new(), 3'($urandom), 200, 1'b0, 2);

    commit_timeout(1'b0);

    back_to_back(1'b0, 1'b0);
    back_to_back(1'b1, 1'b0);
    back_to_back(1'b0, 1'b1);
    back_to_back(1'b1, 1'b1);

    commit(13'd50, 3'd5, 0, 1'b0, 1);
    chk("frac_zero", 32'(bus.BAUD_VAL_FRACTION), 0);
    write(13'd50, 3'd3);
    chk("frac_same_done",    32'(bus.cfg_done), 1);
    chk("frac_same_quiesce", 32'(bus.uart_quiesce), 0);
    chk("frac_same_frac",    32'(bus.BAUD_VAL_FRACTION), 0);
    step();

    commit_timeout(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
